// File: rtl/filtr_stream_ctrl.sv
// Stream-to-filter adapter: accepts one valid/ready sample, strobes the notch filter, returns its result.
// Optional FILTR_TIMEOUT_EN macro adds a WAIT-state watchdog with a sticky err_timeout flag.

module filtr_stream_ctrl_chk #(
  parameter int DATA_SIZE      = 24,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 filt_sample,
  input logic                 in_ready,
  input logic                 out_valid,
  input logic                 out_ready,
  input logic [DATA_SIZE-1:0] out_data
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // The filter strobe is a single-cycle pulse.
  a_strobe_pulse : assert property (@(posedge clk) disable iff (!reset)
    filt_sample |=> !filt_sample);

  // Input is never accepted while a result is still pending downstream.
  a_no_accept_in_hold : assert property (@(posedge clk) disable iff (!reset)
    out_valid |-> !in_ready);

  // A stalled result keeps its valid and data until taken.
  a_hold_stable : assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

module filtr_stream_ctrl #(
  parameter int DATA_SIZE      = 24,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_SIZE       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_SIZE-1:0] filt_data_in,
  output logic                 filt_sample,
  input  logic [DATA_SIZE-1:0] filt_data_out,
  input  logic                 filt_done,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [CNT_SIZE-1:0]  sample_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state_r;

`ifdef FILTR_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt_r;
`endif

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      in_ready     <= 1'b0;
      filt_data_in <= '0;
      filt_sample  <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      sample_cnt   <= '0;
`ifdef FILTR_TIMEOUT_EN
      wait_cnt_r   <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            filt_data_in <= in_data;
            in_ready     <= 1'b0;
            filt_sample  <= 1'b1;
            busy         <= 1'b1;
            state_r      <= TRIG;
          end else begin
            in_ready     <= 1'b1;
          end
        end
        // filt_done is deliberately not looked at here: the filter needs at least one cycle.
        TRIG: begin
          filt_sample <= 1'b0;
          state_r     <= WAIT;
`ifdef FILTR_TIMEOUT_EN
          wait_cnt_r  <= '0;
`endif
        end
        WAIT: begin
          if (filt_done) begin
            out_data    <= filt_data_out;
            out_valid   <= 1'b1;
            state_r     <= HOLD;
`ifdef FILTR_TIMEOUT_EN
          end else if (wait_cnt_r == WAIT_LAST) begin
            out_data    <= '0;
            out_valid   <= 1'b1;
            err_timeout <= 1'b1;
            state_r     <= HOLD;
`endif
          end else begin
`ifdef FILTR_TIMEOUT_EN
            wait_cnt_r  <= wait_cnt_r + TW'(1);
`endif
            state_r     <= WAIT;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            sample_cnt <= sample_cnt + CNT_SIZE'(1);
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            state_r    <= IDLE;
          end else begin
            state_r    <= HOLD;
          end
        end
        default: begin
          filt_sample <= 1'b0;
          out_valid   <= 1'b0;
          in_ready    <= 1'b0;
          busy        <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  filtr_stream_ctrl_chk #(
    .DATA_SIZE      (DATA_SIZE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .filt_sample (filt_sample),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

endmodule

// File: tb/tb_filtr_stream_ctrl.sv
// Directed bench for filtr_stream_ctrl with a behavioural filter model (latency in cycles after the strobe).
// Build with FILTR_TIMEOUT_EN to exercise the watchdog path instead of the indefinite-wait path.

module tb_filtr_stream_ctrl;

  localparam int DW = 24;
  localparam int CW = 8;
  localparam logic [DW-1:0] XMASK = 24'hA5A5A5;
  localparam logic [DW-1:0] SPUR_DATA = 24'hDEAD00;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] filt_data_in;
  logic          filt_sample;
  logic [DW-1:0] filt_data_out;
  logic          filt_done;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          err_timeout;
  logic [CW-1:0] sample_cnt;

  int n_total;
  int n_bad;
  int exp_cnt;
  int strobe_cnt;

  // filter model controls
  bit            resp_en;
  int            resp_lat;
  bit            ovr_en;
  logic [DW-1:0] ovr_val;
  int            cd;
  logic          model_done;
  logic [DW-1:0] model_data;
  logic          spur;

  filtr_stream_ctrl #(
    .DATA_SIZE      (DW),
    .TIMEOUT_CYCLES (64),
    .CNT_SIZE       (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .filt_data_in  (filt_data_in),
    .filt_sample   (filt_sample),
    .filt_data_out (filt_data_out),
    .filt_done     (filt_done),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .sample_cnt    (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign filt_done     = model_done | spur;
  assign filt_data_out = spur ? SPUR_DATA : model_data;

  // Filter model and strobe monitor, both evaluated away from the active edge.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (filt_sample) strobe_cnt = strobe_cnt + 1;
    if (filt_sample && resp_en) begin
      cd = resp_lat;
    end else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        model_done = 1'b1;
        model_data = ovr_en ? ovr_val : (filt_data_in ^ XMASK);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    int k;
    k = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val("send_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic finish_xfer();
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 1;
    check_val("cnt", {24'd0, sample_cnt}, exp_cnt & 32'hFF);
  endtask

  task automatic xfer(input logic [DW-1:0] d);
    send(d);
    wait_ov("x_ov");
    check_val("x_data", {8'd0, out_data}, {8'd0, d ^ XMASK});
    finish_xfer();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int bad;
    logic [DW-1:0] exp2;
    n_total = 0; n_bad = 0; exp_cnt = 0; strobe_cnt = 0;
    reset = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    resp_en = 1'b1; resp_lat = 1; ovr_en = 1'b0; ovr_val = '0;
    cd = 0; model_done = 1'b0; model_data = '0; spur = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_sample", {31'd0, filt_sample}, 32'd0);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_err", {31'd0, err_timeout}, 32'd0);
    check_val("rst_fdin", {8'd0, filt_data_in}, 32'd0);
    check_val("rst_out_data", {8'd0, out_data}, 32'd0);
    check_val("rst_cnt", {24'd0, sample_cnt}, 32'd0);
    reset = 1'b1;
    #1;
    check_val("rel_rdy0", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_val("rel_rdy1", {31'd0, in_ready}, 32'd1);

    // test 1: single sample, latency 5
    ovr_en = 1'b1; ovr_val = 24'hABCDEF; resp_lat = 5; s0 = strobe_cnt;
    send(24'h123456);
    check_val("t1_fdin", {8'd0, filt_data_in}, 32'h00123456);
    check_val("t1_busy", {31'd0, busy}, 32'd1);
    wait_ov("t1_ov");
    check_val("t1_data", {8'd0, out_data}, 32'h00ABCDEF);
    check_val("t1_strobes", strobe_cnt - s0, 32'd1);
    finish_xfer();
    check_val("t1_ov_clr", {31'd0, out_valid}, 32'd0);
    check_val("t1_busy_clr", {31'd0, busy}, 32'd0);
    ovr_en = 1'b0; resp_lat = 1;

    // test 2: 20-cycle back-pressure with next input already offered
    out_ready = 1'b0;
    send(24'h222222);
    wait_ov("t2_ov");
    exp2 = 24'h222222 ^ XMASK;
    check_val("t2_data", {8'd0, out_data}, {8'd0, exp2});
    s0 = strobe_cnt; in_data = 24'h333333; in_valid = 1'b1; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_data !== exp2 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check_val("t2_stall", bad, 32'd0);
    check_val("t2_no_strobe", strobe_cnt - s0, 32'd0);
    out_ready = 1'b1;
    finish_xfer();
    @(negedge clk);
    check_val("t2_rdy_after", {31'd0, in_ready}, 32'd1);
    check_val("t2_no_strobe2", strobe_cnt - s0, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_ov("t2_ov2");
    check_val("t2_data2", {8'd0, out_data}, {8'd0, 24'h333333 ^ XMASK});
    check_val("t2_strobe_one", strobe_cnt - s0, 32'd1);
    finish_xfer();

    // test 3: spurious filt_done in IDLE and in TRIG
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    check_val("t3_idle_ov", {31'd0, out_valid}, 32'd0);
    check_val("t3_idle_busy", {31'd0, busy}, 32'd0);
    check_val("t3_idle_rdy", {31'd0, in_ready}, 32'd1);
    resp_lat = 3;
    @(negedge clk); in_data = 24'h444444; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; spur = 1'b1;
    @(posedge clk); #1; spur = 1'b0;
    @(negedge clk);
    check_val("t3_trig_ov", {31'd0, out_valid}, 32'd0);
    check_val("t3_trig_busy", {31'd0, busy}, 32'd1);
    wait_ov("t3_ov");
    check_val("t3_data", {8'd0, out_data}, {8'd0, 24'h444444 ^ XMASK});
    finish_xfer();

    // test 4: reset during WAIT, late done afterwards
    resp_lat = 10; s0 = strobe_cnt;
    send(24'h555555);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("t4_rdy", {31'd0, in_ready}, 32'd0);
    check_val("t4_sample", {31'd0, filt_sample}, 32'd0);
    check_val("t4_ov", {31'd0, out_valid}, 32'd0);
    check_val("t4_busy", {31'd0, busy}, 32'd0);
    check_val("t4_err", {31'd0, err_timeout}, 32'd0);
    check_val("t4_fdin", {8'd0, filt_data_in}, 32'd0);
    check_val("t4_out_data", {8'd0, out_data}, 32'd0);
    check_val("t4_cnt", {24'd0, sample_cnt}, 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("t4_rel_rdy0", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_val("t4_rel_rdy1", {31'd0, in_ready}, 32'd1);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check_val("t4_late_done", bad, 32'd0);
    check_val("t4_strobes", strobe_cnt - s0, 32'd1);
    resp_lat = 1;

    // test 5: filter never answers
    resp_en = 1'b0;
    send(24'h666666);
`ifdef FILTR_TIMEOUT_EN
    repeat (65) @(negedge clk);
    check_val("t5_pre_ov", {31'd0, out_valid}, 32'd0);
    check_val("t5_pre_err", {31'd0, err_timeout}, 32'd0);
    @(negedge clk);
    check_val("t5_ov", {31'd0, out_valid}, 32'd1);
    check_val("t5_data", {8'd0, out_data}, 32'd0);
    check_val("t5_err", {31'd0, err_timeout}, 32'd1);
    finish_xfer();
    resp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xfer(24'h700000 + 24'(i));
      check_val("t5_err_sticky", {31'd0, err_timeout}, 32'd1);
    end
`else
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check_val("t5_wait_ov", bad, 32'd0);
    check_val("t5_wait_busy", {31'd0, busy}, 32'd1);
    check_val("t5_err", {31'd0, err_timeout}, 32'd0);
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    check_val("t5_late_ov", {31'd0, out_valid}, 32'd1);
    check_val("t5_late_data", {8'd0, out_data}, {8'd0, SPUR_DATA});
    finish_xfer();
    resp_en = 1'b1;
`endif

    // test 6: run the counter through its wrap
    s0 = 256 - (exp_cnt % 256);
    for (int i = 0; i < s0; i++) begin
      xfer(24'(32'h00A00001 + i * 32'h00010F3B));
    end
    check_val("t6_wrap", {24'd0, sample_cnt}, 32'd0);
    xfer(24'h800000);
    xfer(24'h7FFFFF);
    check_val("t6_after_wrap", {24'd0, sample_cnt}, 32'd2);
`ifndef FILTR_TIMEOUT_EN
    check_val("t6_err", {31'd0, err_timeout}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
